// File: rtl/dvga_vmem_pkg.sv
// Shared encodings for the video memory Wishbone slave: FSM states and the
// Wishbone B3 cycle/burst type codes it recognises.
package dvga_vmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/dvga_vmem_ram.sv
// Single-port 2^AW x 32 synchronous RAM with per-byte write enables and a
// registered read port (one cycle latency); contents are never reset.
module dvga_vmem_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   wdat,
  input  logic [3:0]    we,
  output logic [31:0]   rdat
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[adr][8*b +: 8] <= wdat[8*b +: 8];
    end
    rdat <= mem[adr];
  end

endmodule

// File: rtl/dvga_vmem_slave.sv
// Wishbone B3 slave in front of the video RAM: classic cycles plus linear
// incrementing bursts, with read data prefetched for one word per clock.
module dvga_vmem_slave
  import dvga_vmem_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i
);

  state_t        state, state_nxt;
  logic [AW-1:0] rd_adr, rd_adr_nxt, ram_adr;
  logic [3:0]    ram_we;
  logic          req, burst_err;
  logic          unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign burst_err  = (wbs_cti_i == CTI_INCR) && (wbs_bte_i != BTE_LINEAR);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (burst_err)     state_nxt = ST_ERR;
          else if (wbs_we_i) state_nxt = ST_WR;
          else               state_nxt = ST_RD;
        end
      end
      ST_RD, ST_WR: begin
        if (!wbs_cyc_i)                             state_nxt = ST_IDLE;
        else if (wbs_stb_i && wbs_cti_i != CTI_INCR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = 1'b0;
    wbs_err_o = 1'b0;
    ram_we    = 4'b0000;
    case (state)
      ST_RD:   wbs_ack_o = req;
      ST_WR: begin
        wbs_ack_o = req;
        ram_we    = {4{req}} & wbs_sel_i;
      end
      ST_ERR:  wbs_err_o = 1'b1;
      default: ;
    endcase
  end

  // The RAM is addressed with the counter's next value so the word for the
  // upcoming beat is already in the output register when that beat is acked.
  always_comb begin
    rd_adr_nxt = rd_adr;
    if (state == ST_IDLE && req && !wbs_we_i && !burst_err)
      rd_adr_nxt = wbs_adr_i[AW+1:2];
    else if (state == ST_RD && wbs_ack_o)
      rd_adr_nxt = rd_adr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_adr <= '0;
    else     rd_adr <= rd_adr_nxt;
  end

  assign ram_adr = (state == ST_WR) ? wbs_adr_i[AW+1:2] : rd_adr_nxt;

  dvga_vmem_ram #(.AW(AW)) u_ram (
    .clk  (clk),
    .adr  (ram_adr),
    .wdat (wbs_dat_i),
    .we   (ram_we),
    .rdat (wbs_dat_o)
  );

endmodule

// File: tb/tb_dvga_vmem_slave.sv
// Scoreboard bench for dvga_vmem_slave: a bus driver issues directed and random
// transfers against a word-array memory model; a monitor checks every response.
module tb_dvga_vmem_slave;
  import dvga_vmem_pkg::*;

  localparam int AW    = 13;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_w, dat_r;
  logic [3:0]  sel;
  logic        we, stb, cyc, ack, err;
  logic [2:0]  cti;
  logic [1:0]  bte;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_err;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  dvga_vmem_slave #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_dat_o (dat_r),
    .wbs_sel_i (sel),
    .wbs_we_i  (we),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_ack_o (ack),
    .wbs_err_o (err),
    .wbs_cti_i (cti),
    .wbs_bte_i (bte)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Monitor: every ack or err must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (ack || err) begin
      chk("ack_and_err", 32'(ack & err), 32'd0);
      if (expq.size() == 0) begin
        chk("unexpected_resp", 32'({ack, err}), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("resp_err", 32'(err), 32'(e.is_err));
        if (!e.is_err && e.is_read) chk("rd_data", dat_r, e.data);
      end
    end
  end

  // dmode: 0 random data, 1 fdata, 2 word*0x01010101.
  // gap_after=0: no wait states; abort_after/rst_after=-1: not used.
  task automatic xfer(input bit wr, input int word, input int n, input bit burst,
                      input logic [3:0] s, input int dmode, input logic [31:0] fdata,
                      input int gap_after, input int gap_len,
                      input int abort_after, input int rst_after);
    int   k = 0, cycn = 0, first = -1, last = -1, gap = 0, w = 0;
    bit   presented = 0;
    exp_t e;
    cyc = 1'b1; we = wr; sel = s; bte = BTE_LINEAR;
    while (k < n && cycn < 4*n + 40) begin
      w = (word + k) % DEPTH;
      if (k == abort_after) begin
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("abort_ack", 32'(ack), 32'd0);
        @(posedge clk); #1;
        return;
      end
      if (gap > 0) begin
        stb = 1'b0;
      end else begin
        stb = 1'b1;
        adr = 32'(w) << 2;
        cti = burst ? ((k == n-1) ? CTI_END : CTI_INCR) : CTI_CLASSIC;
        if (!presented) begin
          presented = 1;
          case (dmode)
            0:       dat_w = $urandom;
            1:       dat_w = fdata;
            default: dat_w = 32'(w) * 32'h01010101;
          endcase
          e.is_err  = 1'b0;
          e.is_read = !wr;
          if (wr) begin
            model[w] = merge(model[w], dat_w, s);
            e.data   = 32'd0;
          end else begin
            e.data = model[w];
          end
          expq.push_back(e);
        end
        if (k == rst_after) rst = 1'b1;
      end
      @(negedge clk);
      if (gap > 0) begin
        chk("gap_ack", 32'(ack), 32'd0);
        if (!wr) chk("gap_hold", dat_r, model[w]);
        gap--;
      end else if (ack) begin
        if (first < 0) first = cycn;
        last = cycn;
        k++;
        presented = 0;
        if (k == gap_after) gap = gap_len;
      end
      @(posedge clk); #1;
      cycn++;
      if (rst) begin
        rst = 1'b0; stb = 1'b1; cti = CTI_INCR;
        adr = 32'((word + k) % DEPTH) << 2;
        @(negedge clk);
        chk("ack_after_rst", 32'(ack), 32'd0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    if (k < n) begin
      chk("xfer_timeout", k, n);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      return;
    end
    chk("first_ack_cycle", first, 1);
    chk("last_ack_cycle", last, n + ((gap_after > 0 && gap_after < n) ? gap_len : 0));
    // stb still high after the final beat: the block must be in IDLE here
    cti = CTI_END;
    @(negedge clk);
    chk("idle_after_last", 32'(ack), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic err_xfer(input int word);
    exp_t e;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = 32'(word) << 2; dat_w = $urandom; cti = CTI_INCR; bte = 2'b01;
    e.is_err = 1'b1; e.is_read = 1'b0; e.data = 32'd0;
    expq.push_back(e);
    @(negedge clk);
    chk("err_cycle0", 32'({ack, err}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("err_cycle1", 32'({ack, err}), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; bte = BTE_LINEAR;
    @(negedge clk);
    chk("err_cycle2", 32'({ack, err}), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; dat_w = 32'd0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ack", 32'({ack, err}), 32'd0);
    @(posedge clk); #1;

    // Make the whole memory known to the model.
    xfer(1, 0, DEPTH, 1, 4'hF, 0, 32'd0, 0, 0, -1, -1);

    xfer(1, 'h10, 1, 0, 4'hF, 1, 32'hDEADBEEF, 0, 0, -1, -1);
    xfer(0, 'h10, 1, 0, 4'hF, 0, 32'd0, 0, 0, -1, -1);

    xfer(1, 'h40, 8, 1, 4'hF, 2, 32'd0, 0, 0, -1, -1);
    xfer(0, 'h40, 8, 1, 4'hF, 0, 32'd0, 0, 0, -1, -1);
    xfer(0, 'h40, 8, 1, 4'hF, 0, 32'd0, 3, 2, -1, -1);

    xfer(1, DEPTH-2, 4, 1, 4'hF, 2, 32'd0, 0, 0, -1, -1);
    xfer(0, DEPTH-2, 4, 1, 4'hF, 0, 32'd0, 0, 0, -1, -1);

    xfer(1, 'h10, 4, 1, 4'hF, 1, 32'h0, 0, 0, -1, -1);
    xfer(1, 'h10, 4, 1, 4'b0101, 1, 32'hFFFFFFFF, 0, 0, -1, -1);
    xfer(0, 'h10, 4, 1, 4'hF, 0, 32'd0, 0, 0, -1, -1);

    err_xfer('h20);
    xfer(0, 'h20, 1, 0, 4'hF, 0, 32'd0, 0, 0, -1, -1);

    xfer(0, 'h40, 8, 1, 4'hF, 0, 32'd0, 0, 0, 3, -1);
    xfer(0, 'h41, 1, 0, 4'hF, 0, 32'd0, 0, 0, -1, -1);
    xfer(0, 'h40, 8, 1, 4'hF, 0, 32'd0, 0, 0, -1, 4);
    xfer(0, 'h44, 1, 0, 4'hF, 0, 32'd0, 0, 0, -1, -1);

    for (int t = 0; t < 40; t++) begin
      int n, ga, gl, wd;
      bit wr, b;
      n  = $urandom_range(1, 8);
      b  = (n > 1) || ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 1) == 1);
      wd = $urandom_range(0, DEPTH-1);
      ga = (n > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n-1) : 0;
      gl = $urandom_range(1, 3);
      xfer(wr, wd, n, b, 4'($urandom), 0, 32'd0, ga, gl, -1, -1);
      if (wr) xfer(0, wd, n, 1, 4'hF, 0, 32'd0, 0, 0, -1, -1);
    end

    repeat (2) @(posedge clk);
    chk("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
